// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: FSM encodings, parity modes and
// the default bit period for a 77.5 MHz clock at 9600 baud.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 8073;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  // Mode 2'b11 is reserved and behaves as no parity.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty are decoded
// from the count so callers can gate push/pop on registered state.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_Clock,
  input  logic             i_Rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_Clock) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  // Pointers are exactly AW bits wide, so increment wraps modulo DEPTH.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO; frames are LSB first with optional
// parity and one or two stop bits, and queued frames go out back-to-back.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 16,
  parameter int CNT_W        = 16
) (
  input  logic                         i_Clock,
  input  logic                         i_Rst_n,
  input  logic                         i_Tx_DV,
  input  logic [DATA_BITS-1:0]         i_Tx_Byte,
  output logic                         o_Tx_Ready,
  input  logic [1:0]                   i_Parity_Mode,
  input  logic                         i_Two_Stop,
  output logic                         o_Tx_Serial,
  output logic                         o_Tx_Active,
  output logic                         o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH):0]  o_Fifo_Count,
  output logic                         o_Overflow
);

  localparam int                IDX_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]  BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] fifo_data;

  logic [2:0]           state;
  logic [CNT_W-1:0]     bit_tmr;
  logic [IDX_W-1:0]     bit_idx;
  logic                 stop_idx;
  logic [DATA_BITS-1:0] frame_data;
  logic [1:0]           frame_mode;
  logic                 frame_two;

  logic                 bit_tick;
  logic                 frame_end;
  logic                 par_bit;
  logic                 tx_bit;
  logic                 done_p1;

  assign o_Tx_Ready = ~fifo_full;
  assign push       = i_Tx_DV & ~fifo_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_Clock (i_Clock),
    .i_Rst_n (i_Rst_n),
    .push    (push),
    .wr_data (i_Tx_Byte),
    .pop     (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (o_Fifo_Count)
  );

  assign bit_tick  = (bit_tmr == BIT_LAST);
  // The final stop bit is index 1 with two stop bits, index 0 otherwise.
  assign frame_end = (state == S_STOP) && bit_tick && (stop_idx == frame_two);
  assign pop       = ~fifo_empty && ((state == S_IDLE) || frame_end);
  assign par_bit   = (frame_mode == PAR_ODD) ? ~^frame_data : ^frame_data;

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state      <= S_IDLE;
      bit_tmr    <= '0;
      bit_idx    <= '0;
      stop_idx   <= 1'b0;
      frame_mode <= PAR_NONE;
      frame_two  <= 1'b0;
    end else begin
      if (pop) begin
        frame_mode <= i_Parity_Mode;
        frame_two  <= i_Two_Stop;
      end
      if (state == S_IDLE) begin
        bit_tmr <= '0;
        if (pop) state <= S_START;
      end else if (!bit_tick) begin
        bit_tmr <= bit_tmr + 1'b1;
      end else begin
        bit_tmr <= '0;
        case (state)
          S_START: state <= S_DATA;
          S_DATA: begin
            if (bit_idx == IDX_LAST) begin
              bit_idx <= '0;
              state   <= parity_enabled(frame_mode) ? S_PARITY : S_STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end
          S_PARITY: state <= S_STOP;
          S_STOP: begin
            if (!frame_end) begin
              stop_idx <= 1'b1;
            end else begin
              stop_idx <= 1'b0;
              state    <= pop ? S_START : S_IDLE;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge i_Clock) begin
    if (pop) frame_data <= fifo_data;
  end

  always_comb begin
    tx_bit = 1'b1;
    case (state)
      S_START:  tx_bit = 1'b0;
      S_DATA:   tx_bit = frame_data[bit_idx];
      S_PARITY: tx_bit = par_bit;
      default:  tx_bit = 1'b1;
    endcase
  end

  // ---- p1/p2: registered line outputs; done is delayed twice to align with the line
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      done_p1     <= 1'b0;
      o_Tx_Done   <= 1'b0;
      o_Overflow  <= 1'b0;
    end else begin
      o_Tx_Serial <= tx_bit;
      o_Tx_Active <= (state != S_IDLE);
      done_p1     <= frame_end;
      o_Tx_Done   <= done_p1;
      o_Overflow  <= i_Tx_DV & fifo_full;
    end
  end

endmodule
